uart_boot_loader: RTL and testbench

- Serial program loader between the UART byte receiver/transmitter and the PicoRV32 memory write port.
- Holds the CPU in reset after power-up.
- Accepts a framed program image over RX, writes it word-by-word into instruction memory, and replies ACK/NAK on TX.
- Releases the CPU only after a frame with a valid checksum.

---
 rtl/uart_boot_loader.sv | 175 +++++++++++++++++
 tb/tb_uart_boot_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed program image over the UART byte
// stream, writes it word-by-word into instruction memory, answers ACK/NAK
// and holds the CPU in reset until a frame with a good checksum lands.
// Optional build macro: UART_BOOT_REARM_EN (a sync byte in DONE starts a reload).
module uart_boot_loader #(
  parameter logic [31:0] BaseAddr      = 32'h0000_0000,
  parameter int unsigned MaxWords      = 4096,
  parameter int unsigned TimeoutCycles = 1200000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ready_i,
  output logic        cpu_reset_o,
  output logic        boot_done_o,
  output logic        error_o
);

  localparam int unsigned ToW      = $clog2(TimeoutCycles + 1);
  localparam logic [7:0]  SyncByte = 8'hA5;
  localparam logic [7:0]  AckByte  = 8'h06;
  localparam logic [7:0]  NakByte  = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_RESP, S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_len, r_widx;
  logic [1:0]      r_bcnt;
  logic [7:0]      r_csum, r_tx_data;
  logic [31:0]     r_word, r_addr;
  logic [ToW-1:0]  r_to;
  logic            r_rx_ready, r_mem_valid, r_tx_valid;
  logic            r_cpu_reset, r_boot_done, r_error;

  logic            w_rx_fire, w_tx_fire, w_mem_fire;
  logic            w_to_active, w_to_hit, w_sync;
  logic [15:0]     w_len_full;
  logic [7:0]      w_resp;

  assign w_rx_fire  = rx_valid_i & r_rx_ready;
  assign w_tx_fire  = r_tx_valid & tx_ready_i;
  assign w_mem_fire = r_mem_valid & mem_ready_i;

  assign rx_ready_o  = r_rx_ready;
  assign tx_valid_o  = r_tx_valid;
  assign tx_data_o   = r_tx_data;
  assign mem_valid_o = r_mem_valid;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_word;
  assign mem_wstrb_o = r_mem_valid ? 4'hF : 4'h0;
  assign cpu_reset_o = r_cpu_reset;
  assign boot_done_o = r_boot_done;
  assign error_o     = r_error;

  // Next-state logic, response selection and inter-byte timeout detection
  always_comb begin
    w_state_nxt = r_state;
    w_resp      = r_tx_data;
    w_sync      = 1'b0;
    w_len_full  = {rx_data_i, r_len[7:0]};
    w_to_active = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                  (r_state == S_DATA) || (r_state == S_CSUM);
    w_to_hit    = w_to_active && !w_rx_fire && (r_to == ToW'(TimeoutCycles - 1));
    case (r_state)
      S_IDLE: begin
        if (w_rx_fire && rx_data_i == SyncByte) begin
          w_state_nxt = S_LEN0;
          w_sync      = 1'b1;
        end
      end
      S_LEN0: if (w_rx_fire) w_state_nxt = S_LEN1;
      S_LEN1: begin
        if (w_rx_fire) begin
          if (32'(w_len_full) > MaxWords) begin
            w_state_nxt = S_RESP;
            w_resp      = NakByte;
          end else if (w_len_full == 16'd0) begin
            w_state_nxt = S_CSUM;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: if (w_rx_fire && r_bcnt == 2'd3) w_state_nxt = S_WRITE;
      S_WRITE: begin
        if (w_mem_fire) w_state_nxt = (r_widx == 16'(r_len - 16'd1)) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (w_rx_fire) begin
          w_state_nxt = S_RESP;
          w_resp      = (rx_data_i == r_csum) ? AckByte : NakByte;
        end
      end
      S_RESP: if (w_tx_fire) w_state_nxt = (r_tx_data == AckByte) ? S_DONE : S_IDLE;
      S_DONE: begin
`ifdef UART_BOOT_REARM_EN
        if (w_rx_fire && rx_data_i == SyncByte) begin
          w_state_nxt = S_LEN0;
          w_sync      = 1'b1;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_to_hit) w_state_nxt = S_IDLE;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Datapath and registered outputs, decoded from the upcoming state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_len       <= 16'd0;
      r_widx      <= 16'd0;
      r_bcnt      <= 2'd0;
      r_csum      <= 8'd0;
      r_tx_data   <= 8'd0;
      r_word      <= 32'd0;
      r_addr      <= BaseAddr;
      r_to        <= '0;
      r_rx_ready  <= 1'b1;
      r_mem_valid <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_boot_done <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_rx_ready  <= (w_state_nxt != S_WRITE) && (w_state_nxt != S_RESP);
      r_mem_valid <= (w_state_nxt == S_WRITE);
      r_tx_valid  <= (w_state_nxt == S_RESP);
      r_cpu_reset <= (w_state_nxt != S_DONE);
      r_boot_done <= (w_state_nxt == S_DONE);

      if (w_sync) begin
        r_csum  <= 8'd0;
        r_widx  <= 16'd0;
        r_bcnt  <= 2'd0;
        r_addr  <= BaseAddr;
        r_error <= 1'b0;
      end
      if (r_state == S_LEN0 && w_rx_fire) r_len[7:0]  <= rx_data_i;
      if (r_state == S_LEN1 && w_rx_fire) r_len[15:8] <= rx_data_i;
      if (r_state == S_DATA && w_rx_fire) begin
        r_word <= {rx_data_i, r_word[31:8]};
        r_csum <= r_csum ^ rx_data_i;
        r_bcnt <= r_bcnt + 2'd1;
      end
      if (r_state == S_WRITE && w_mem_fire) begin
        r_widx <= r_widx + 16'd1;
        r_addr <= r_addr + 32'd4;
      end
      if (w_state_nxt == S_RESP && r_state != S_RESP) r_tx_data <= w_resp;
      if ((r_state == S_RESP && w_tx_fire && r_tx_data == NakByte) || w_to_hit) r_error <= 1'b1;

      if (!w_to_active || w_rx_fire || w_state_nxt != r_state) r_to <= '0;
      else                                                       r_to <= r_to + ToW'(1);
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: random-gap byte stimulus against a frame-level
// reference model; a monitor process scores memory writes and tx bytes.
module tb_uart_boot_loader;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned MAXW  = 4096;
  localparam int unsigned TO    = 300;
  localparam logic [7:0]  ACK   = 8'h06;
  localparam logic [7:0]  NAK   = 8'h15;
`ifdef UART_BOOT_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i;
  logic        cpu_reset_o;
  logic        boot_done_o;
  logic        error_o;

  uart_boot_loader #(.BaseAddr(BASE), .MaxWords(MAXW), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i),
    .cpu_reset_o(cpu_reset_o), .boot_done_o(boot_done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_delay = 0;
  int          tx_delay  = 0;
  int          max_gap   = 2;
  bit          booted   = 1'b0;
  bit          exp_err  = 1'b0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  exp_tx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory/transmitter ready generators with configurable stall lengths
  initial begin : ready_gen
    int mc, tc;
    mc = 0; tc = 0;
    mem_ready_i = 1'b0;
    tx_ready_i  = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (mem_valid_o) begin mem_ready_i = (mc >= mem_delay); mc++; end
      else begin mem_ready_i = 1'b0; mc = 0; end
      if (tx_valid_o) begin tx_ready_i = (tc >= tx_delay); tc++; end
      else begin tx_ready_i = 1'b0; tc = 0; end
    end
  end

  // Monitor: scores writes/responses and checks handshake stability rules
  initial begin : monitor
    bit          pend_mem, pend_tx, ack_prev;
    logic [31:0] pa, pd;
    logic [7:0]  pt;
    pend_mem = 1'b0; pend_tx = 1'b0; ack_prev = 1'b0;
    pa = '0; pd = '0; pt = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        pend_mem = 1'b0; pend_tx = 1'b0; ack_prev = 1'b0;
        continue;
      end
      if (ack_prev) begin
        check("cpu_reset_after_ack", 32'(cpu_reset_o), 32'd0);
        check("boot_done_after_ack", 32'(boot_done_o), 32'd1);
      end
      ack_prev = 1'b0;
      if (pend_mem) begin
        check("mem_hold_valid", 32'(mem_valid_o), 32'd1);
        check("mem_hold_addr", mem_addr_o, pa);
        check("mem_hold_data", mem_wdata_o, pd);
      end
      if (pend_tx) begin
        check("tx_hold_valid", 32'(tx_valid_o), 32'd1);
        check("tx_hold_data", 32'(tx_data_o), 32'(pt));
      end
      check("wstrb", 32'(mem_wstrb_o), mem_valid_o ? 32'hF : 32'h0);
      if (mem_valid_o || tx_valid_o) begin
        check("mem_tx_exclusive", 32'(mem_valid_o & tx_valid_o), 32'd0);
        check("rx_ready_busy", 32'(rx_ready_o), 32'd0);
        check("cpu_reset_busy", 32'(cpu_reset_o), 32'd1);
      end
      if (mem_valid_o && mem_ready_i) begin
        check("mem_expected", 32'(exp_addr.size() != 0), 32'd1);
        if (exp_addr.size() != 0) begin
          check("mem_addr", mem_addr_o, exp_addr.pop_front());
          check("mem_data", mem_wdata_o, exp_data.pop_front());
        end
      end
      if (tx_valid_o && tx_ready_i) begin
        check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) check("tx_byte", 32'(tx_data_o), 32'(exp_tx.pop_front()));
        if (tx_data_o == ACK) ack_prev = 1'b1;
      end
      pend_mem = mem_valid_o && !mem_ready_i;
      pend_tx  = tx_valid_o && !tx_ready_i;
      pa = mem_addr_o; pd = mem_wdata_o; pt = tx_data_o;
    end
  end

  // Present one byte and hold it until the loader accepts it
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (rx_ready_o) break;
      n++;
      if (n > 2000) begin
        check("rx_accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    repeat ($urandom_range(0, max_gap)) begin @(posedge clk_i); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_addr.size() != 0 || exp_tx.size() != 0) && n < 5000) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("drain_pending", 32'(exp_addr.size() + exp_tx.size()), 32'd0);
    repeat (10) begin @(posedge clk_i); #1; end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_cpu_reset"}, 32'(cpu_reset_o), 32'(!booted));
    check({tag, "_boot_done"}, 32'(boot_done_o), 32'(booted));
    check({tag, "_error"},     32'(error_o),     32'(exp_err));
    check({tag, "_rx_ready"},  32'(rx_ready_o),  32'd1);
  endtask

  // Frame-level reference: predicts writes, response and boot outcome
  task automatic run_frame(input logic [31:0] words[$], input logic [15:0] len,
                           input logic [7:0] csum_flip, input string tag);
    logic [7:0] bytes[$];
    logic [7:0] cs, b;
    bit         active, was_booted, ack;
    cs = 8'h00;
    was_booted = booted;
    active = !booted || REARM;
    bytes.push_back(8'hA5);
    bytes.push_back(len[7:0]);
    bytes.push_back(len[15:8]);
    if (32'(len) > MAXW) begin
      if (active) begin exp_tx.push_back(NAK); exp_err = 1'b1; booted = 1'b0; end
    end else begin
      foreach (words[i]) begin
        for (int k = 0; k < 4; k++) begin
          b = 8'((words[i] >> (8 * k)) & 32'hFF);
          bytes.push_back(b);
          cs = cs ^ b;
        end
        if (active) begin
          exp_addr.push_back(BASE + 32'(4 * i));
          exp_data.push_back(words[i]);
        end
      end
      bytes.push_back(cs ^ csum_flip);
      if (active) begin
        ack = (csum_flip == 8'h00);
        exp_tx.push_back(ack ? ACK : NAK);
        exp_err = !ack;
        booted  = ack;
      end
    end
    foreach (bytes[i]) begin
      send_gap(bytes[i]);
      if (i == 0 && was_booted) begin
        check({tag, "_sync_cpu_reset"}, 32'(cpu_reset_o), 32'(REARM));
        check({tag, "_sync_boot_done"}, 32'(boot_done_o), 32'(!REARM));
      end
    end
    drain();
    check_status(tag);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    rx_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    booted = 1'b0;
    exp_err = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    exp_tx.delete();
  endtask

  initial begin : stim
    logic [31:0] w[$];
    logic [31:0] none[$];
    int          len, n;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    rst_ni     = 1'b0;
    do_reset();

    check("rst_cpu_reset", 32'(cpu_reset_o), 32'd1);
    check("rst_boot_done", 32'(boot_done_o), 32'd0);
    check("rst_error",     32'(error_o),     32'd0);
    check("rst_mem_valid", 32'(mem_valid_o), 32'd0);
    check("rst_tx_valid",  32'(tx_valid_o),  32'd0);
    check("rst_rx_ready",  32'(rx_ready_o),  32'd1);

    // Junk before sync is discarded
    send_gap(8'h33);
    send_gap(8'h5A);

    w = '{32'h12345678, 32'hDEADBEEF};
    run_frame(w, 16'd2, 8'h01, "bad_csum");
    run_frame(none, 16'h1001, 8'h00, "oversize");

    for (int i = 0; i < 6; i++) begin
      mem_delay = $urandom_range(0, 3);
      tx_delay  = $urandom_range(0, 3);
      len = $urandom_range(1, 5);
      w.delete();
      for (int j = 0; j < len; j++) w.push_back($urandom);
      run_frame(w, 16'(len), 8'($urandom_range(1, 255)), "rand_bad");
    end

    // Stall after 3 data bytes until the inter-byte timeout fires
    mem_delay = 0; tx_delay = 0;
    send_gap(8'hA5); send_gap(8'h03); send_gap(8'h00);
    send_gap(8'h11); send_gap(8'h22); send_byte(8'h33);
    repeat (TO - 10) @(posedge clk_i);
    #1;
    check("to_error_early", 32'(error_o), 32'd0);
    repeat (20) @(posedge clk_i);
    #1;
    check("to_error", 32'(error_o), 32'd1);
    check("to_cpu_reset", 32'(cpu_reset_o), 32'd1);
    check("to_rx_ready", 32'(rx_ready_o), 32'd1);
    exp_err = 1'b1;

    // Good load under backpressure, after earlier failures
    mem_delay = 5; tx_delay = 3;
    w = '{32'h12345678, 32'hDEADBEEF};
    run_frame(w, 16'd2, 8'h00, "good");

    // A further frame after boot: reload when re-arming is built in, else ignored
    mem_delay = 1; tx_delay = 1;
    w = '{$urandom, $urandom, $urandom};
    run_frame(w, 16'd3, 8'h00, "post_boot");

    // Reset in the middle of a write
    do_reset();
    mem_delay = 100000;
    send_gap(8'hA5); send_gap(8'h01); send_gap(8'h00);
    send_gap(8'hAA); send_gap(8'hBB); send_gap(8'hCC); send_byte(8'hDD);
    n = 0;
    while (!mem_valid_o && n < 50) begin @(negedge clk_i); n++; end
    check("rst_wr_pre_valid", 32'(mem_valid_o), 32'd1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    check("rst_wr_mem_valid", 32'(mem_valid_o), 32'd0);
    check("rst_wr_cpu_reset", 32'(cpu_reset_o), 32'd1);
    do_reset();
    mem_delay = 0; tx_delay = 0;

    run_frame(none, 16'd0, 8'h00, "zero_len");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
